bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 109 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift-and-adjust iteration per clock,
// result registered on completion and held until the next conversion finishes.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned BcdW = 4 * DIGITS;

    typedef enum logic [0:0] {StIdle, StConv} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BcdW-1:0]   scratch_q, scratch_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;

    logic [BcdW-1:0]   adj;
    logic [BcdW-1:0]   scratch_next;
    logic              last_iter;

    // Every digit is corrected from its pre-shift value, all in parallel.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign scratch_next = {adj[BcdW-2:0], shift_q[WIDTH-1]};
    assign last_iter    = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    shift_d   = bin;
                    scratch_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = StConv;
                end
            end
            StConv: begin
                scratch_d = scratch_next;
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q + CntW'(1);
                // Publish only the finished value so bcd never shows partial sums.
                if (last_iter) begin
                    bcd_d   = scratch_next;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes decimal-model results, a monitor
// pops and compares on every done pulse.
module tb_bin_to_bcd_seq;

    localparam int unsigned W = 16;
    localparam int unsigned D = 5;

    typedef struct {
        logic [4*D-1:0] val;
        int unsigned    at;
        int unsigned    src;
    } exp_t;

    logic           clk = 1'b0;
    logic           clr;
    logic           start;
    logic [W-1:0]   bin;
    logic           busy;
    logic           done;
    logic [4*D-1:0] bcd;

    int unsigned    cyc = 0;
    int             errors = 0;
    int             checks = 0;
    exp_t           sb[$];
    exp_t           e;
    logic [4*D-1:0] last_bcd;
    logic           prev_done;
    logic           bad_digit;
    bit             mon_en = 1'b0;

    bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain repeated division by ten.
    function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
        logic [4*D-1:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(D); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !clr) begin
            if (done) begin
                check("done_one_cycle", {31'd0, prev_done}, 32'd0);
                check("busy_low_at_done", {31'd0, busy}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got bcd=%0h, expected no done (cycle %0d)",
                             bcd, cyc);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("bcd_value(bin=%0d)", e.src), 32'(bcd), 32'(e.val));
                    check($sformatf("done_latency(bin=%0d)", e.src), cyc, e.at);
                end
                bad_digit = 1'b0;
                for (int i = 0; i < int'(D); i++) begin
                    if (bcd[4*i +: 4] > 4'd9) bad_digit = 1'b1;
                end
                check("digit_le_9", {31'd0, bad_digit}, 32'd0);
                last_bcd = bcd;
            end else begin
                check("bcd_hold", 32'(bcd), 32'(last_bcd));
            end
            prev_done = done;
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 clr = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        last_bcd  = '0;
        prev_done = 1'b0;
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_done", {31'd0, done}, 32'd0);
        check("clr_bcd", 32'(bcd), 32'd0);
        clr = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (busy && n < 200);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=1, expected busy=0 within 200 cycles");
        end
    endtask

    // Drives start for exactly one edge; bin is scrambled right after acceptance.
    task automatic issue(input logic [W-1:0] v);
        wait_idle();
        start = 1'b1;
        bin   = v;
        sb.push_back('{val: ref_bcd(32'(v)), at: cyc + 17, src: 32'(v)});
        @(posedge clk);
        #1 start = 1'b0;
        bin = W'($urandom);
    endtask

    initial begin
        int n;
        logic [W-1:0] v;
        clr   = 1'b1;
        start = 1'b0;
        bin   = '0;
        do_reset();
        mon_en = 1'b1;

        // Zero and full-scale, with busy-width measurement.
        issue(16'd0);
        issue(16'd65535);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) break;
            if (busy) n++;
        end
        check("busy_cycles", 32'(n), 32'd16);

        // Start during conversion must be ignored.
        issue(16'd1234);
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        bin = 16'd9999;
        @(posedge clk);
        #1 start = 1'b0;

        // Abort mid-conversion, then a normal conversion.
        issue(16'd500);
        repeat (6) @(posedge clk);
        do_reset();
        issue(16'd42);

        // Back-to-back: start held in the done cycle.
        issue(16'd9);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) break;
        end
        start = 1'b1;
        bin   = 16'd10;
        sb.push_back('{val: ref_bcd(32'd10), at: cyc + 17, src: 32'd10});
        @(posedge clk);
        #1 start = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            if (i == 0) v = 16'd9999;
            else if (i == 1) v = 16'd10000;
            else if (i == 2) v = 16'd65535;
            else v = W'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            issue(v);
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending results, expected 0", sb.size());
        end
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
